// File: rtl/dom_pkg.sv
// Shared helpers for the masked AND: pair enumeration and share-slice addressing.
// Used by the RTL and the bench so both agree on the randomness layout.
package dom_pkg;

  function automatic int num_pairs(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Lexicographic index of the unordered pair {i,j}; symmetric in i and j.
  function automatic int pair_index(input int n, input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * (2 * n - lo - 1) / 2 + (hi - lo - 1);
  endfunction

  function automatic int share_bit(input int s, input int lane, input int w);
    return s * w + lane;
  endfunction

endpackage

// File: rtl/dom_and_pipe_if.sv
// Operand/randomness/result bus of the masked AND with valid/ready on both sides.
interface dom_and_pipe_if import dom_pkg::*; #(
  parameter int NUM_SHARES = 3,
  parameter int WIDTH      = 1
);
  localparam int NUM_PAIRS = num_pairs(NUM_SHARES);

  logic [NUM_SHARES*WIDTH-1:0] io_i0;
  logic [NUM_SHARES*WIDTH-1:0] io_i1;
  logic [NUM_PAIRS*WIDTH-1:0]  p_rand;
  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_SHARES*WIDTH-1:0] io_o0;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output io_i0, io_i1, p_rand, in_valid, out_ready,
    input  in_ready, io_o0, out_valid
  );

  modport slave (
    input  io_i0, io_i1, p_rand, in_valid, out_ready,
    output in_ready, io_o0, out_valid
  );
endinterface

// File: rtl/dom_and_lane.sv
// One bit lane of the DOM AND: resharing register of NUM_SHARES^2 terms, then
// an integration register fed only from the resharing register outputs.
module dom_and_lane import dom_pkg::*; #(
  parameter  int NUM_SHARES = 3,
  localparam int NUM_PAIRS  = num_pairs(NUM_SHARES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en1,
  input  logic                  i_en2,
  input  logic [NUM_SHARES-1:0] i_a,
  input  logic [NUM_SHARES-1:0] i_b,
  input  logic [NUM_PAIRS-1:0]  i_rand,
  output logic [NUM_SHARES-1:0] o_share
);

  // Row i holds every term that integrates into output share i; the diagonal
  // is the unmasked inner product, off-diagonals are the blinded cross terms.
  logic [NUM_SHARES-1:0][NUM_SHARES-1:0] w_term;
  logic [NUM_SHARES-1:0][NUM_SHARES-1:0] r_term;
  logic [NUM_SHARES-1:0]                 w_int;
  logic [NUM_SHARES-1:0]                 r_share;

  for (genvar gi = 0; gi < NUM_SHARES; gi++) begin : g_row
    for (genvar gj = 0; gj < NUM_SHARES; gj++) begin : g_col
      if (gi == gj) begin : g_inner
        assign w_term[gi][gj] = i_a[gi] & i_b[gj];
      end else begin : g_cross
        localparam int K = pair_index(NUM_SHARES, gi, gj);
        assign w_term[gi][gj] = (i_a[gi] & i_b[gj]) ^ i_rand[K];
      end
    end
    assign w_int[gi] = ^r_term[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_term  <= '0;
      r_share <= '0;
    end else begin
      if (i_en1) r_term  <= w_term;
      if (i_en2) r_share <= w_int;
    end
  end

  assign o_share = r_share;

endmodule

// File: rtl/dom_and_pipe.sv
// Pipelined DOM AND gadget: WIDTH independent lanes under one two-entry
// elastic valid/ready control.
module dom_and_pipe import dom_pkg::*; #(
  parameter  int NUM_SHARES = 3,
  parameter  int WIDTH      = 1,
  localparam int NUM_PAIRS  = num_pairs(NUM_SHARES)
) (
  input logic           clock_0,
  input logic           reset_0,
  dom_and_pipe_if.slave bus
);

  logic [2:1] r_vld_pipe;
  logic       w_en2;
  logic       w_in_ready;
  logic       w_accept;

  logic [WIDTH-1:0][NUM_SHARES-1:0] w_a;
  logic [WIDTH-1:0][NUM_SHARES-1:0] w_b;
  logic [WIDTH-1:0][NUM_SHARES-1:0] w_o;
  logic [WIDTH-1:0][NUM_PAIRS-1:0]  w_r;
  logic [NUM_SHARES*WIDTH-1:0]      w_o_flat;

  // Stage 2 advances when it is empty or being drained; stage 1 can take a new
  // operand whenever its current content moves on in the same edge.
  assign w_en2      = r_vld_pipe[1] & (~r_vld_pipe[2] | bus.out_ready);
  assign w_in_ready = ~r_vld_pipe[1] | w_en2;
  assign w_accept   = bus.in_valid & w_in_ready;

  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= w_accept | (r_vld_pipe[1] & ~w_en2);
      r_vld_pipe[2] <= w_en2 | (r_vld_pipe[2] & ~bus.out_ready);
    end
  end

  for (genvar gl = 0; gl < WIDTH; gl++) begin : g_lane
    for (genvar gs = 0; gs < NUM_SHARES; gs++) begin : g_share
      assign w_a[gl][gs] = bus.io_i0[share_bit(gs, gl, WIDTH)];
      assign w_b[gl][gs] = bus.io_i1[share_bit(gs, gl, WIDTH)];
      assign w_o_flat[share_bit(gs, gl, WIDTH)] = w_o[gl][gs];
    end
    for (genvar gk = 0; gk < NUM_PAIRS; gk++) begin : g_pair
      assign w_r[gl][gk] = bus.p_rand[share_bit(gk, gl, WIDTH)];
    end

    dom_and_lane #(.NUM_SHARES(NUM_SHARES)) u_lane (
      .clk    (clock_0),
      .rst_n  (reset_0),
      .i_en1  (w_accept),
      .i_en2  (w_en2),
      .i_a    (w_a[gl]),
      .i_b    (w_b[gl]),
      .i_rand (w_r[gl]),
      .o_share(w_o[gl])
    );
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld_pipe[2];
  assign bus.io_o0     = w_o_flat;

endmodule

// File: tb/tb_dom_and_pipe.sv
// Directed + scoreboard bench for dom_and_pipe at (3 shares, 1 lane) and (4 shares, 8 lanes).
module tb_dom_and_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dom_and_pipe_if #(.NUM_SHARES(3), .WIDTH(1)) if3();
  dom_and_pipe_if #(.NUM_SHARES(4), .WIDTH(8)) if4();

  dom_and_pipe #(.NUM_SHARES(3), .WIDTH(1)) u_dut3 (.clock_0(clk), .reset_0(rst_n), .bus(if3));
  dom_and_pipe #(.NUM_SHARES(4), .WIDTH(8)) u_dut4 (.clock_0(clk), .reset_0(rst_n), .bus(if4));

  int n_pass = 0;
  int n_tot  = 0;
  int acc3 = 0, out3 = 0, acc4 = 0, out4 = 0;
  logic [31:0] q3[$];
  logic [31:0] q4[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rec3(input logic [2:0] v);
    return {31'b0, ^v};
  endfunction

  function automatic logic [31:0] rec4(input logic [31:0] v);
    return {24'b0, v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push recombined AND on accept, pop and compare on delivery.
  always @(negedge clk) begin
    if (!rst_n) begin
      q3.delete();
      q4.delete();
    end else begin
      if (if3.out_valid && if3.out_ready) begin
        out3++;
        if (q3.size() == 0) check("sb3_extra_output", 32'(q3.size()), 32'd1);
        else check("sb3_result", rec3(if3.io_o0), q3.pop_front());
      end
      if (if3.in_valid && if3.in_ready) begin
        q3.push_back(rec3(if3.io_i0) & rec3(if3.io_i1));
        acc3++;
      end
      if (if4.out_valid && if4.out_ready) begin
        out4++;
        if (q4.size() == 0) check("sb4_extra_output", 32'(q4.size()), 32'd1);
        else check("sb4_result", rec4(if4.io_o0), q4.pop_front());
      end
      if (if4.in_valid && if4.in_ready) begin
        q4.push_back(rec4(if4.io_i0) & rec4(if4.io_i1));
        acc4++;
      end
    end
  end

  initial begin
    int base;
    int idx;
    int cycles;
    logic [2:0] held;
    logic [2:0] sa [3];
    logic [2:0] sb [3];

    if3.io_i0 = '0; if3.io_i1 = '0; if3.p_rand = '0; if3.in_valid = 1'b0; if3.out_ready = 1'b1;
    if4.io_i0 = '0; if4.io_i1 = '0; if4.p_rand = '0; if4.in_valid = 1'b0; if4.out_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset held with random activity on the inputs
    repeat (3) begin
      tick();
      if3.io_i0 = 3'($urandom); if3.io_i1 = 3'($urandom); if3.p_rand = 3'($urandom);
      if3.in_valid = 1'($urandom); if3.out_ready = 1'($urandom);
      if4.io_i0 = $urandom; if4.io_i1 = $urandom; if4.p_rand = 48'({$urandom, $urandom});
      if4.in_valid = 1'($urandom); if4.out_ready = 1'($urandom);
      check("rst_o3", 32'(if3.io_o0), 32'd0);
      check("rst_v3", 32'(if3.out_valid), 32'd0);
      check("rst_o4", if4.io_o0, 32'd0);
      check("rst_v4", 32'(if4.out_valid), 32'd0);
    end
    if3.in_valid = 1'b0; if3.out_ready = 1'b1;
    if4.in_valid = 1'b0; if4.out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    check("rst_ready3", 32'(if3.in_ready), 32'd1);
    check("rst_ready4", 32'(if4.in_ready), 32'd1);

    // Directed single operand
    tick();
    if3.io_i0 = 3'b001; if3.io_i1 = 3'b111; if3.p_rand = 3'b111; if3.in_valid = 1'b1;
    tick();
    if3.in_valid = 1'b0;
    check("dir_not_yet_valid", 32'(if3.out_valid), 32'd0);
    tick();
    check("dir_valid", 32'(if3.out_valid), 32'd1);
    check("dir_shares", 32'(if3.io_o0), 32'h1);
    tick();
    check("dir_valid_one_cycle", 32'(if3.out_valid), 32'd0);

    // Exhaustive shares x randomness, back-to-back
    base = out3;
    for (int c = 0; c < 512; c++) begin
      tick();
      if3.io_i0 = c[2:0]; if3.io_i1 = c[5:3]; if3.p_rand = c[8:6]; if3.in_valid = 1'b1;
    end
    tick();
    if3.in_valid = 1'b0;
    tick();
    tick();
    check("exh_count", 32'(out3 - base), 32'd512);

    // Stall: downstream blocked for 5 cycles, 3 operands offered
    for (int i = 0; i < 3; i++) begin
      sa[i] = 3'($urandom);
      sb[i] = 3'($urandom);
    end
    base = out3;
    idx  = 0;
    held = '0;
    if3.out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if3.p_rand   = 3'($urandom);
      if3.in_valid = (idx < 3);
      if (idx < 3) begin
        if3.io_i0 = sa[idx];
        if3.io_i1 = sb[idx];
      end
      @(negedge clk);
      if (if3.in_valid && if3.in_ready) idx++;
      if (cyc == 2) held = if3.io_o0;
      if (cyc > 2) check("stall_hold", 32'(if3.io_o0), 32'(held));
      tick();
    end
    check("stall_accepted", 32'(idx), 32'd2);
    check("stall_in_ready", 32'(if3.in_ready), 32'd0);
    check("stall_out_valid", 32'(if3.out_valid), 32'd1);
    if3.out_ready = 1'b1;
    #1;
    check("stall_release_ready", 32'(if3.in_ready), 32'd1);
    @(negedge clk);
    if (if3.in_valid && if3.in_ready) idx++;
    tick();
    if3.in_valid = 1'b0;
    check("stall_third_accepted", 32'(idx), 32'd3);
    tick();
    tick();
    tick();
    check("stall_drain_count", 32'(out3 - base), 32'd3);

    // Random traffic, 4 shares x 8 lanes
    cycles = 0;
    while (acc4 < 10000 && cycles < 50000) begin
      if4.io_i0 = $urandom; if4.io_i1 = $urandom; if4.p_rand = 48'({$urandom, $urandom});
      if4.in_valid = ($urandom_range(3) != 0);
      if4.out_ready = 1'($urandom_range(1));
      tick();
      cycles++;
    end
    if4.in_valid = 1'b0;
    if4.out_ready = 1'b1;
    check("rnd_accepted", 32'(acc4), 32'd10000);
    repeat (4) tick();
    check("rnd_delivered", 32'(out4), 32'(acc4));
    check("rnd_sb_empty", 32'(q4.size()), 32'd0);

    // Reset while both stages are full
    if3.out_ready = 1'b0;
    if3.io_i0 = 3'b001; if3.io_i1 = 3'b111; if3.p_rand = 3'b111; if3.in_valid = 1'b1;
    tick();
    tick();
    if3.in_valid = 1'b0;
    check("mf_full_valid", 32'(if3.out_valid), 32'd1);
    check("mf_full_shares", 32'(if3.io_o0), 32'h1);
    check("mf_full_ready", 32'(if3.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mf_async_o", 32'(if3.io_o0), 32'd0);
    check("mf_async_v", 32'(if3.out_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    if3.out_ready = 1'b1;
    #1;
    check("mf_post_valid", 32'(if3.out_valid), 32'd0);
    check("mf_post_ready", 32'(if3.in_ready), 32'd1);
    base = out3;
    tick();
    if3.io_i0 = 3'b011; if3.io_i1 = 3'b111; if3.p_rand = 3'($urandom); if3.in_valid = 1'b1;
    tick();
    if3.in_valid = 1'b0;
    tick();
    check("mf_new_valid", 32'(if3.out_valid), 32'd1);
    check("mf_new_result", rec3(if3.io_o0), 32'd0);
    tick();
    check("mf_new_count", 32'(out3 - base), 32'd1);
    check("sb3_empty", 32'(q3.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
